// File: rtl/counter_32_pkg.sv
// Shared constants and types for the counter_32 block.
package counter_32_pkg;

    localparam int COUNTER_32_DEFAULT_WIDTH = 32;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/counter_32_next.sv
// Combinational next-count logic: load beats enable, wrap flags carry/borrow.
// Wrap detection only exists when COUNTER_32_TC_EN is defined.
module counter_32_next
    import counter_32_pkg::*;
#(
    parameter int WIDTH = COUNTER_32_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_en,
    input  logic             i_up_dn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_next
`ifdef COUNTER_32_TC_EN
    ,
    output logic             o_wrap
`endif
);

    dir_e w_dir;
    assign w_dir = dir_e'(i_up_dn);

    always_comb begin
        o_next = i_count;
        if (i_load) begin
            o_next = i_load_value;
        end else if (i_en) begin
            if (w_dir == DIR_UP) begin
                o_next = i_count + WIDTH'(1);
            end else begin
                o_next = i_count - WIDTH'(1);
            end
        end
    end

`ifdef COUNTER_32_TC_EN
    // A load never reports a wrap, even when it lands on a wrap value.
    always_comb begin
        o_wrap = 1'b0;
        if (!i_load && i_en) begin
            if (w_dir == DIR_UP) begin
                o_wrap = &i_count;
            end else begin
                o_wrap = ~|i_count;
            end
        end
    end
`endif

endmodule

// File: rtl/counter_32.sv
// Up/down counter with sync load/enable and async active-low reset.
// Define COUNTER_32_TC_EN to add the registered terminal-count pulse tc.
module counter_32
    import counter_32_pkg::*;
#(
    parameter int WIDTH = COUNTER_32_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
`ifdef COUNTER_32_TC_EN
    ,
    output logic             tc
`endif
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

`ifdef COUNTER_32_TC_EN
    logic r_tc;
    logic w_wrap;
`endif

    counter_32_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_count      (r_count),
        .i_en         (en),
        .i_up_dn      (up_dn),
        .i_load       (load),
        .i_load_value (load_value),
        .o_next       (w_next)
`ifdef COUNTER_32_TC_EN
        ,
        .o_wrap       (w_wrap)
`endif
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

`ifdef COUNTER_32_TC_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= w_wrap;
        end
    end

    assign tc = r_tc;
`endif

    assign count = r_count;

endmodule

// File: tb/tb_counter_32.sv
// Self-checking bench for counter_32: directed scenarios plus random traffic
// against an arithmetic reference model (tc checked when COUNTER_32_TC_EN).
module tb_counter_32;

    localparam longint unsigned MOD = 64'h1_0000_0000;
    localparam longint unsigned MAX = MOD - 1;

    logic        clk;
    logic        reset;
    logic        en;
    logic        up_dn;
    logic        load;
    logic [31:0] load_value;
    logic [31:0] count;
`ifdef COUNTER_32_TC_EN
    logic        tc;
`endif

    int passed = 0;
    int total  = 0;

    longint unsigned mc;
    bit              mtc;

    counter_32 #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up_dn      (up_dn),
        .load       (load),
        .load_value (load_value),
        .count      (count)
`ifdef COUNTER_32_TC_EN
        ,
        .tc         (tc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 64'(count), mc);
`ifdef COUNTER_32_TC_EN
        chk({tag, ".tc"}, 64'(tc), 64'(mtc));
`endif
    endtask

    // One clock: drive inputs, step the model by the counter's rules, compare.
    task automatic cyc(input string tag, input bit l, input logic [31:0] lv,
                       input bit e, input bit u);
        load       = l;
        load_value = lv;
        en         = e;
        up_dn      = u;
        @(posedge clk);
        #1;
        mtc = 1'b0;
        if (l) begin
            mc = 64'(lv);
        end else if (e && u) begin
            mtc = (mc == MAX);
            mc  = (mc + 1) % MOD;
        end else if (e) begin
            mtc = (mc == 0);
            mc  = (mc + MOD - 1) % MOD;
        end
        chk_all(tag);
    endtask

    initial begin
        logic [31:0] rv;
        int          sel;

        reset      = 1'b0;
        en         = 1'b1;
        up_dn      = 1'b1;
        load       = 1'b0;
        load_value = '0;
        mc         = 0;
        mtc        = 1'b0;

        #3;
        chk_all("rst_t3");
        #5;
        chk_all("rst_t8");
        #2;
        reset = 1'b1;

        for (int i = 1; i <= 10; i++) cyc("count_up", 0, 0, 1, 1);
        chk("after10", 64'(count), 64'd10);
        cyc("to11", 0, 0, 1, 1);

        #2;
        reset = 1'b0;
        mc    = 0;
        mtc   = 1'b0;
        #1;
        chk_all("midrst");
        #2;
        reset = 1'b1;
        cyc("resume1", 0, 0, 1, 1);
        cyc("resume2", 0, 0, 1, 1);

        cyc("wrapup_ld", 1, 32'hFFFF_FFFE, 1, 1);
        cyc("wrapup_1", 0, 0, 1, 1);
        cyc("wrapup_2", 0, 0, 1, 1);
        cyc("wrapup_hold", 0, 0, 0, 1);

        cyc("wrapdn_ld", 1, 32'h0000_0001, 1, 0);
        cyc("wrapdn_1", 0, 0, 1, 0);
        cyc("wrapdn_2", 0, 0, 1, 0);
        cyc("wrapdn_hold", 0, 0, 0, 0);

        cyc("prio_ld", 1, 32'h0000_1234, 1, 1);
        chk("prio_val", 64'(count), 64'h1234);
        for (int i = 0; i < 5; i++) cyc("hold", 0, 0, 0, 1);

        cyc("ldmax", 1, 32'hFFFF_FFFF, 0, 1);
        cyc("ld0", 1, 32'h0000_0000, 1, 1);
        cyc("ldmax_dn", 1, 32'h0000_0000, 0, 0);
        cyc("ld_wrapdn", 1, 32'hFFFF_FFFF, 1, 0);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rv = $urandom;
                1:       rv = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: rv = 32'($urandom_range(0, 3));
            endcase
            cyc("rand", ($urandom_range(0, 9) == 0), rv,
                ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
